// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - ShiftRows/InvShiftRows stage with per-beat direction and output FIFO
module shift_rows_pipe #(
  parameter int CELL_W = 4,
  parameter int NB     = 2,
  parameter int DEPTH  = 2,
  localparam int W     = NB * NB * CELL_W,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_inv,
  input  logic [W-1:0]  in_data,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  shifted;
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          push;
  logic          pop;

  // Cells are column-major, MSB first; each output cell is a pure wire selection.
  for (genvar c = 0; c < NB; c++) begin : g_col
    for (genvar r = 0; r < NB; r++) begin : g_row
      localparam int ENC = (c + r) % NB;
      localparam int DEC = (c - r + NB) % NB;
      assign shifted[W-1-(c*NB+r)*CELL_W -: CELL_W] = in_inv
          ? in_data[W-1-(DEC*NB+r)*CELL_W -: CELL_W]
          : in_data[W-1-(ENC*NB+r)*CELL_W -: CELL_W];
    end
  end

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // in_ready depends only on registered occupancy, never on out_ready.
  assign in_ready  = !rst && !flush && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shifted;
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - randomized bench for shift_rows_pipe against a row-rotation queue model
module tb_shift_rows_pipe;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic         a_valid, a_inv, a_flush, a_oready;
  logic [15:0]  a_data;
  logic         a_iready, a_ovalid;
  logic [15:0]  a_odata;
  logic [1:0]   a_count;

  logic         b_valid, b_inv, b_flush, b_oready;
  logic [127:0] b_data;
  logic         b_iready, b_ovalid;
  logic [127:0] b_odata;
  logic [1:0]   b_count;

  logic [15:0]  aq [$];
  logic [127:0] bq [$];

  shift_rows_pipe #(.CELL_W(4), .NB(2), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_iready), .in_inv(a_inv),
    .in_data(a_data), .flush(a_flush), .out_valid(a_ovalid), .out_ready(a_oready),
    .out_data(a_odata), .count(a_count)
  );

  shift_rows_pipe #(.CELL_W(8), .NB(4), .DEPTH(3)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_iready), .in_inv(b_inv),
    .in_data(b_data), .flush(b_flush), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_data(b_odata), .count(b_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Row r of the state is rotated left by r (encrypt) or right by r (decrypt).
  function automatic logic [127:0] shift_ref(input logic [127:0] d, input int nb,
                                             input int cw, input bit inv);
    logic [7:0]   m [4][4];
    logic [127:0] res;
    logic [127:0] mask;
    int w, src;
    w    = nb * nb * cw;
    mask = (128'd1 << cw) - 128'd1;
    res  = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < nb; r++)
        m[r][c] = 8'((d >> (w - (c * nb + r + 1) * cw)) & mask);
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < nb; r++) begin
        src = inv ? (c - r + nb) % nb : (c + r) % nb;
        res = res | (128'(m[r][src]) << (w - (c * nb + r + 1) * cw));
      end
    return res;
  endfunction

  task automatic tick_a(output bit pushed);
    bit ps, pp, fl, rs;
    logic [127:0] d;
    @(negedge clk);
    rs = rst;
    fl = a_flush;
    ps = a_valid && !rs && !fl && (aq.size() < 2);
    pp = (aq.size() != 0) && a_oready;
    d  = shift_ref({112'd0, a_data}, 2, 4, a_inv);
    @(posedge clk);
    #1;
    if (rs || fl) aq.delete();
    else begin
      if (pp) void'(aq.pop_front());
      if (ps) aq.push_back(d[15:0]);
    end
    pushed = ps;
  endtask

  task automatic tick_b(output bit pushed);
    bit ps, pp, fl, rs;
    logic [127:0] d;
    @(negedge clk);
    rs = rst;
    fl = b_flush;
    ps = b_valid && !rs && !fl && (bq.size() < 3);
    pp = (bq.size() != 0) && b_oready;
    d  = shift_ref(b_data, 4, 8, b_inv);
    @(posedge clk);
    #1;
    if (rs || fl) bq.delete();
    else begin
      if (pp) void'(bq.pop_front());
      if (ps) bq.push_back(d);
    end
    pushed = ps;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    a_valid = 0; a_inv = 0; a_flush = 0; a_oready = 0; a_data = '0;
    b_valid = 0; b_inv = 0; b_flush = 0; b_oready = 0; b_data = '0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL reset_ovalid got=%b exp=0", a_ovalid); end
    total++; if (a_odata !== 16'h0) begin bad++; $display("FAIL reset_odata got=%h exp=0", a_odata); end
    total++; if (a_iready !== 1'b0) begin bad++; $display("FAIL reset_iready got=%b exp=0", a_iready); end
    total++; if (b_iready !== 1'b0) begin bad++; $display("FAIL reset_b_iready got=%b exp=0", b_iready); end
    rst = 1'b0;
    #1;
    total++; if (a_iready !== 1'b1) begin bad++; $display("FAIL post_reset_iready got=%b exp=1", a_iready); end
    total++; if (b_iready !== 1'b1) begin bad++; $display("FAIL post_reset_b_iready got=%b exp=1", b_iready); end
  endtask

  task automatic test_vectors_nb2;
    logic [15:0] din [2];
    logic [15:0] dex [2];
    bit p;
    din[0] = 16'h1234; dex[0] = 16'h1432;
    din[1] = 16'h1432; dex[1] = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1; a_data = din[i]; a_inv = 1'(i); a_oready = 0;
      tick_a(p);
      a_valid = 0;
      total++; if (a_ovalid !== 1'b1) begin bad++; $display("FAIL nb2_ovalid[%0d] got=%b exp=1", i, a_ovalid); end
      total++; if (a_odata !== dex[i]) begin bad++; $display("FAIL nb2_golden[%0d] got=%h exp=%h", i, a_odata, dex[i]); end
      total++; if (a_count !== 2'd1) begin bad++; $display("FAIL nb2_count[%0d] got=%0d exp=1", i, a_count); end
      a_oready = 1;
      tick_a(p);
      a_oready = 0;
      total++; if (a_count !== 2'd0) begin bad++; $display("FAIL nb2_drain[%0d] got=%0d exp=0", i, a_count); end
      total++; if (a_odata !== 16'h0) begin bad++; $display("FAIL nb2_empty_data[%0d] got=%h exp=0", i, a_odata); end
    end
  endtask

  task automatic test_vectors_nb4;
    logic [127:0] dex [2];
    bit p;
    dex[0] = 128'h00050a0f04090e03080d02070c01060b;
    dex[1] = 128'h000d0a0704010e0b0805020f0c090603;
    for (int i = 0; i < 2; i++) begin
      b_valid = 1; b_data = 128'h000102030405060708090a0b0c0d0e0f; b_inv = 1'(i); b_oready = 0;
      tick_b(p);
      b_valid = 0;
      total++; if (b_odata !== dex[i]) begin bad++; $display("FAIL nb4_golden[%0d] got=%h exp=%h", i, b_odata, dex[i]); end
      total++; if (b_ovalid !== 1'b1) begin bad++; $display("FAIL nb4_ovalid[%0d] got=%b exp=1", i, b_ovalid); end
      b_oready = 1;
      tick_b(p);
      b_oready = 0;
      total++; if (b_count !== 2'd0) begin bad++; $display("FAIL nb4_drain[%0d] got=%0d exp=0", i, b_count); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] held;
    bit p;
    a_oready = 0;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1; a_data = 16'($urandom); a_inv = 1'($urandom_range(1));
      tick_a(p);
    end
    total++; if (a_count !== 2'd2) begin bad++; $display("FAIL bp_full_count got=%0d exp=2", a_count); end
    total++; if (a_iready !== 1'b0) begin bad++; $display("FAIL bp_full_iready got=%b exp=0", a_iready); end
    a_data = 16'($urandom); a_inv = 1'($urandom_range(1));
    held = a_odata;
    for (int i = 0; i < 2; i++) begin
      tick_a(p);
      total++; if (a_count !== 2'd2) begin bad++; $display("FAIL bp_hold_count got=%0d exp=2", a_count); end
      total++; if (a_odata !== held) begin bad++; $display("FAIL bp_stable got=%h exp=%h", a_odata, held); end
    end
    total++; if (a_odata !== aq[0]) begin bad++; $display("FAIL bp_head got=%h exp=%h", a_odata, aq[0]); end
    a_oready = 1;
    for (int i = 0; i < 5; i++) begin
      tick_a(p);
      if (p) a_valid = 0;
      total++; if (a_count !== 2'(aq.size())) begin bad++; $display("FAIL bp_drain_count[%0d] got=%0d exp=%0d", i, a_count, aq.size()); end
      if (aq.size() != 0) begin
        total++; if (a_odata !== aq[0]) begin bad++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, a_odata, aq[0]); end
      end
    end
    a_oready = 0; a_valid = 0;
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL bp_final_ovalid got=%b exp=0", a_ovalid); end
  endtask

  task automatic test_flush;
    bit p;
    a_oready = 0;
    for (int i = 0; i < 2; i++) begin
      a_valid = 1; a_data = 16'($urandom); a_inv = 1'($urandom_range(1));
      tick_a(p);
    end
    total++; if (a_count !== 2'd2) begin bad++; $display("FAIL flush_pre_count got=%0d exp=2", a_count); end
    a_flush = 1; a_valid = 1; a_data = 16'($urandom); a_inv = 1'($urandom_range(1)); a_oready = 1;
    #1;
    total++; if (a_iready !== 1'b0) begin bad++; $display("FAIL flush_iready got=%b exp=0", a_iready); end
    tick_a(p);
    total++; if (a_count !== 2'd0) begin bad++; $display("FAIL flush_count got=%0d exp=0", a_count); end
    total++; if (a_ovalid !== 1'b0) begin bad++; $display("FAIL flush_ovalid got=%b exp=0", a_ovalid); end
    total++; if (a_odata !== 16'h0) begin bad++; $display("FAIL flush_odata got=%h exp=0", a_odata); end
    a_flush = 0; a_oready = 0;
    tick_a(p);
    a_valid = 0;
    total++; if (a_count !== 2'd1) begin bad++; $display("FAIL flush_repush_count got=%0d exp=1", a_count); end
    total++; if (a_odata !== aq[0]) begin bad++; $display("FAIL flush_repush_data got=%h exp=%h", a_odata, aq[0]); end
    a_oready = 1;
    tick_a(p);
    a_oready = 0;
    total++; if (a_count !== 2'd0) begin bad++; $display("FAIL flush_drain got=%0d exp=0", a_count); end
  endtask

  task automatic test_streaming;
    bit p;
    b_oready = 1; b_valid = 1;
    for (int i = 0; i < 24; i++) begin
      b_data = {$urandom, $urandom, $urandom, $urandom};
      b_inv  = 1'(i % 2);
      tick_b(p);
      total++; if (b_count !== 2'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d exp=1", i, b_count); end
      total++; if (b_odata !== bq[0]) begin bad++; $display("FAIL stream_data[%0d] got=%h exp=%h", i, b_odata, bq[0]); end
      total++; if (b_iready !== 1'b1) begin bad++; $display("FAIL stream_iready[%0d] got=%b exp=1", i, b_iready); end
    end
    b_valid = 0;
    tick_b(p);
    b_oready = 0;
    total++; if (b_count !== 2'd0) begin bad++; $display("FAIL stream_drain got=%0d exp=0", b_count); end
  endtask

  task automatic test_reset_mid;
    bit p;
    b_valid = 1; b_data = {$urandom, $urandom, $urandom, $urandom}; b_inv = 0; b_oready = 0;
    tick_b(p);
    total++; if (b_count !== 2'd1) begin bad++; $display("FAIL mid_pre_count got=%0d exp=1", b_count); end
    rst = 1; b_data = {$urandom, $urandom, $urandom, $urandom}; b_oready = 1;
    tick_b(p);
    total++; if (b_count !== 2'd0) begin bad++; $display("FAIL mid_count got=%0d exp=0", b_count); end
    total++; if (b_ovalid !== 1'b0) begin bad++; $display("FAIL mid_ovalid got=%b exp=0", b_ovalid); end
    total++; if (b_odata !== 128'h0) begin bad++; $display("FAIL mid_odata got=%h exp=0", b_odata); end
    total++; if (b_iready !== 1'b0) begin bad++; $display("FAIL mid_iready got=%b exp=0", b_iready); end
    rst = 0; b_oready = 0;
    #1;
    total++; if (b_iready !== 1'b1) begin bad++; $display("FAIL mid_release_iready got=%b exp=1", b_iready); end
    b_data = {$urandom, $urandom, $urandom, $urandom}; b_inv = 1;
    tick_b(p);
    b_valid = 0;
    total++; if (b_ovalid !== 1'b1) begin bad++; $display("FAIL mid_first_ovalid got=%b exp=1", b_ovalid); end
    total++; if (b_odata !== bq[0]) begin bad++; $display("FAIL mid_first_data got=%h exp=%h", b_odata, bq[0]); end
    b_oready = 1;
    tick_b(p);
    b_oready = 0;
    total++; if (b_count !== 2'd0) begin bad++; $display("FAIL mid_drain got=%0d exp=0", b_count); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_vectors_nb2;
    test_vectors_nb4;
    test_back_to_back;
    test_flush;
    test_streaming;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
